// File: rtl/cdc_gate_arbiter.sv
`default_nettype none
// ============================================================================
// cdc_gate_arbiter : round-robin share of one CdcGate source port, {id,payload}
// Rev 1.0
// ============================================================================
module cdc_gate_arbiter #(
  parameter  int REQUESTERS = 4,
  parameter  int WIDTH      = 8,
  localparam int IDW        = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [REQUESTERS-1:0]       reqValid_i,
  input  logic [REQUESTERS*WIDTH-1:0] reqData_i,
  output logic [REQUESTERS-1:0]       reqReady_o,
  input  logic                        gateOpen_i,
  output logic                        gateWrite_o,
  output logic [WIDTH+IDW-1:0]        gateData_o,
  output logic [15:0]                 writes_o
);

  localparam logic [1:0] S_OPEN    = 2'd0;
  localparam logic [1:0] S_WRITE   = 2'd1;
  localparam logic [1:0] S_CLOSING = 2'd2;
  localparam logic [1:0] S_REOPEN  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [WIDTH+IDW-1:0] data_q, data_d;
  logic [15:0]          writes_q, writes_d;

  logic                 found_w;
  logic [IDW-1:0]       grantIdx_w;
  logic [WIDTH-1:0]     grantData_w;
  logic                 accept_w;
  int                   cand_w;

  // Scan ptr, ptr+1, ... wrapping at REQUESTERS (not at 2**IDW).
  always_comb begin
    found_w     = 1'b0;
    grantIdx_w  = '0;
    grantData_w = '0;
    cand_w      = 0;
    for (int i = 0; i < REQUESTERS; i++) begin
      cand_w = int'(ptr_q) + i;
      if (cand_w >= REQUESTERS) begin
        cand_w = cand_w - REQUESTERS;
      end
      if (!found_w && reqValid_i[cand_w]) begin
        found_w     = 1'b1;
        grantIdx_w  = IDW'(cand_w);
        grantData_w = reqData_i[cand_w*WIDTH +: WIDTH];
      end
    end
  end

  assign accept_w = (state_q == S_OPEN) && gateOpen_i && found_w && !rst_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_REOPEN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OPEN:    if (accept_w)    state_d = S_WRITE;
      S_WRITE:                    state_d = S_CLOSING;
      S_CLOSING: if (!gateOpen_i) state_d = S_REOPEN;
      S_REOPEN:  if (gateOpen_i)  state_d = S_OPEN;
      default:                    state_d = S_REOPEN;
    endcase
  end

  // Output logic
  always_comb begin
    reqReady_o  = '0;
    gateWrite_o = 1'b0;
    if (accept_w) begin
      reqReady_o = REQUESTERS'(1) << grantIdx_w;
    end
    if ((state_q == S_WRITE) && !rst_i) begin
      gateWrite_o = 1'b1;
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    data_d   = data_q;
    writes_d = writes_q;
    if (accept_w) begin
      ptr_d  = (int'(grantIdx_w) == REQUESTERS - 1) ? '0 : grantIdx_w + IDW'(1);
      data_d = {grantIdx_w, grantData_w};
    end
    if (state_q == S_WRITE) begin
      writes_d = writes_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q    <= '0;
      data_q   <= '0;
      writes_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      data_q   <= data_d;
      writes_q <= writes_d;
    end
  end

  assign gateData_o = data_q;
  assign writes_o   = writes_q;

endmodule
`default_nettype wire
